// File: rtl/id_stage_hazard.sv
// ID/EX pipeline register with load-use hazard stalls, branch flush and a halt-drain FSM.
// Optional bubble performance counter is built when PERF_COUNT_EN is defined.
module id_stage_hazard #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR      = 11,
  parameter int CANT_BITS_CTRL      = 12,
  parameter int LOAD_LATENCY        = 1,
  parameter int HALT_DRAIN          = 3,
  localparam int RB                 = $clog2(CANT_REGISTROS)
) (
  input  logic                           i_clock,
  input  logic                           i_soft_reset,
  input  logic                           i_enable_pipeline,
  input  logic                           i_valid_id,
  input  logic [RB-1:0]                  i_reg_rs,
  input  logic [RB-1:0]                  i_reg_rt,
  input  logic [RB-1:0]                  i_reg_rd,
  input  logic                           i_uses_rt,
  input  logic [CANT_BITS_REGISTROS-1:0] i_data_A,
  input  logic [CANT_BITS_REGISTROS-1:0] i_data_B,
  input  logic [CANT_BITS_REGISTROS-1:0] i_imm_ext,
  input  logic [CANT_BITS_CTRL-1:0]      i_ctrl,
  input  logic                           i_mem_read,
  input  logic                           i_halt,
  input  logic [CANT_BITS_ADDR-1:0]      i_pc,
  input  logic                           i_ex_mem_read,
  input  logic [RB-1:0]                  i_ex_reg_dst,
  input  logic                           i_flush,
  output logic                           o_stall,
  output logic                           o_valid,
  output logic                           o_mem_read,
  output logic                           o_halt_detected,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_A,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_B,
  output logic [CANT_BITS_REGISTROS-1:0] o_imm_ext,
  output logic [RB-1:0]                  o_reg_rs,
  output logic [RB-1:0]                  o_reg_rt,
  output logic [RB-1:0]                  o_reg_rd,
  output logic [CANT_BITS_CTRL-1:0]      o_ctrl,
  output logic [CANT_BITS_ADDR-1:0]      o_pc,
  output logic [1:0]                     o_state,
  output logic                           o_halted,
  output logic [15:0]                    o_bubble_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LATENCY - 1);
  localparam logic [2:0] DRAIN_CNT = 3'(HALT_DRAIN);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       hazard_s;
  logic       bubble_s;
  logic       halt_pulse_s;
  logic       count_bubble_s;

  // Register zero is hard-wired, so a load targeting it never creates a dependency.
  assign hazard_s = (state_r == RUN) & i_valid_id & i_ex_mem_read &
                    (i_ex_reg_dst != {RB{1'b0}}) &
                    ((i_ex_reg_dst == i_reg_rs) | (i_uses_rt & (i_ex_reg_dst == i_reg_rt)));

  assign o_stall = hazard_s | (state_r != RUN);
  assign o_state = state_r;

  // Next-state, counter and bubble selection in edge-priority order.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bubble_s       = 1'b1;
    halt_pulse_s   = 1'b0;
    count_bubble_s = 1'b0;
    case (state_r)
      HALTED: begin
        state_nxt_s = HALTED;
      end
      DRAIN: begin
        cnt_nxt_s = cnt_r - 3'd1;
        if (cnt_r == 3'd1) state_nxt_s = HALTED;
        else               state_nxt_s = DRAIN;
      end
      STALL: begin
        if (i_flush) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 3'd0;
        end else begin
          count_bubble_s = 1'b1;
          cnt_nxt_s      = cnt_r - 3'd1;
          if (cnt_r == 3'd1) state_nxt_s = RUN;
          else               state_nxt_s = STALL;
        end
      end
      RUN: begin
        if (i_flush) begin
          state_nxt_s = RUN;
        end else if (hazard_s) begin
          count_bubble_s = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_nxt_s = STALL;
            cnt_nxt_s   = LOAD_CNT;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (i_halt && i_valid_id) begin
          bubble_s     = 1'b0;
          halt_pulse_s = 1'b1;
          state_nxt_s  = DRAIN;
          cnt_nxt_s    = DRAIN_CNT;
        end else begin
          bubble_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // ID/EX register; data fields always capture, control fields are zeroed in bubbles.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_r         <= RUN;
      cnt_r           <= 3'd0;
      o_halted        <= 1'b0;
      o_valid         <= 1'b0;
      o_mem_read      <= 1'b0;
      o_halt_detected <= 1'b0;
      o_ctrl          <= {CANT_BITS_CTRL{1'b0}};
      o_data_A        <= {CANT_BITS_REGISTROS{1'b0}};
      o_data_B        <= {CANT_BITS_REGISTROS{1'b0}};
      o_imm_ext       <= {CANT_BITS_REGISTROS{1'b0}};
      o_reg_rs        <= {RB{1'b0}};
      o_reg_rt        <= {RB{1'b0}};
      o_reg_rd        <= {RB{1'b0}};
      o_pc            <= {CANT_BITS_ADDR{1'b0}};
    end else if (i_enable_pipeline) begin
      state_r         <= state_nxt_s;
      cnt_r           <= cnt_nxt_s;
      o_halted        <= (state_nxt_s == HALTED);
      o_valid         <= bubble_s ? 1'b0 : i_valid_id;
      o_mem_read      <= bubble_s ? 1'b0 : i_mem_read;
      o_halt_detected <= halt_pulse_s;
      o_ctrl          <= bubble_s ? {CANT_BITS_CTRL{1'b0}} : i_ctrl;
      o_data_A        <= i_data_A;
      o_data_B        <= i_data_B;
      o_imm_ext       <= i_imm_ext;
      o_reg_rs        <= i_reg_rs;
      o_reg_rt        <= i_reg_rt;
      o_reg_rd        <= i_reg_rd;
      o_pc            <= i_pc;
    end
  end

`ifdef PERF_COUNT_EN
  logic [15:0] bubble_count_r;

  // Saturating count of hazard bubbles only; flush and drain bubbles are excluded.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      bubble_count_r <= 16'd0;
    end else if (i_enable_pipeline && count_bubble_s && (bubble_count_r != 16'hFFFF)) begin
      bubble_count_r <= bubble_count_r + 16'd1;
    end
  end

  assign o_bubble_count = bubble_count_r;
`else
  logic perf_unused_s;
  assign perf_unused_s  = count_bubble_s;
  assign o_bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_stage_hazard.sv
// Self-checking bench for id_stage_hazard: vector table plus hand sequences, scoreboard-checked.
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, vid, uses_rt, mr, halt, exmr, flush;
  logic [4:0]  rs, rt, exdst;
  logic [31:0] a;

  logic        o_stall, o_valid, o_mem_read, o_halt_detected, o_halted;
  logic [31:0] o_data_A, o_data_B, o_imm_ext;
  logic [4:0]  o_reg_rs, o_reg_rt, o_reg_rd;
  logic [11:0] o_ctrl;
  logic [10:0] o_pc;
  logic [1:0]  o_state;
  logic [15:0] o_bubble_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        live;
    logic        hdet;
    logic [1:0]  state;
    logic [31:0] data_a;
    logic [4:0]  rs;
  } exp_t;

  typedef struct {
    logic        vid, uses_rt, exmr, flush, halt;
    logic [4:0]  rs, rt, exdst;
    logic [31:0] a;
    logic        stall;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  id_stage_hazard #(.LOAD_LATENCY(3), .HALT_DRAIN(3)) dut (
    .i_clock(clk), .i_soft_reset(rst_n), .i_enable_pipeline(en), .i_valid_id(vid),
    .i_reg_rs(rs), .i_reg_rt(rt), .i_reg_rd(rs ^ 5'd1), .i_uses_rt(uses_rt),
    .i_data_A(a), .i_data_B(~a), .i_imm_ext(a + 32'd1), .i_ctrl(12'hA5A),
    .i_mem_read(mr), .i_halt(halt), .i_pc(a[10:0]), .i_ex_mem_read(exmr),
    .i_ex_reg_dst(exdst), .i_flush(flush),
    .o_stall(o_stall), .o_valid(o_valid), .o_mem_read(o_mem_read),
    .o_halt_detected(o_halt_detected), .o_data_A(o_data_A), .o_data_B(o_data_B),
    .o_imm_ext(o_imm_ext), .o_reg_rs(o_reg_rs), .o_reg_rt(o_reg_rt), .o_reg_rd(o_reg_rd),
    .o_ctrl(o_ctrl), .o_pc(o_pc), .o_state(o_state), .o_halted(o_halted),
    .o_bubble_count(o_bubble_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic l, input logic h,
                              input logic [1:0] s, input logic [31:0] d, input logic [4:0] r);
    exp_t e;
    e.valid = v; e.live = l; e.hdet = h; e.state = s; e.data_a = d; e.rs = r;
    return e;
  endfunction

  function automatic vec_t mv(input logic v, input logic [4:0] r_s, input logic [4:0] r_t,
                              input logic u, input logic xm, input logic [4:0] xd,
                              input logic fl, input logic [31:0] d, input logic st, input exp_t e);
    vec_t t;
    t.vid = v; t.rs = r_s; t.rt = r_t; t.uses_rt = u; t.exmr = xm; t.exdst = xd;
    t.flush = fl; t.halt = 1'b0; t.a = d; t.stall = st; t.e = e;
    return t;
  endfunction

  // Check combinational stall, queue the registered expectation, then compare after the edge.
  task automatic step(input string nm, input logic exp_stall, input exp_t e);
    exp_t x;
    #1;
    check({nm, "/stall"}, {31'd0, o_stall}, {31'd0, exp_stall});
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({nm, "/scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check({nm, "/valid"},  {31'd0, o_valid}, {31'd0, x.valid});
      check({nm, "/ctrl"},   {20'd0, o_ctrl}, x.live ? 32'h0000_0A5A : 32'd0);
      check({nm, "/memrd"},  {31'd0, o_mem_read}, {31'd0, x.live});
      check({nm, "/hdet"},   {31'd0, o_halt_detected}, {31'd0, x.hdet});
      check({nm, "/state"},  {30'd0, o_state}, {30'd0, x.state});
      check({nm, "/halted"}, {31'd0, o_halted}, {31'd0, (x.state == 2'd3)});
      check({nm, "/data_a"}, o_data_A, x.data_a);
      check({nm, "/data_b"}, o_data_B, ~x.data_a);
      check({nm, "/rs"},     {27'd0, o_reg_rs}, {27'd0, x.rs});
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, "/valid"},  {31'd0, o_valid}, 32'd0);
    check({nm, "/hdet"},   {31'd0, o_halt_detected}, 32'd0);
    check({nm, "/ctrl"},   {20'd0, o_ctrl}, 32'd0);
    check({nm, "/data_a"}, o_data_A, 32'd0);
    check({nm, "/pc"},     {21'd0, o_pc}, 32'd0);
    check({nm, "/state"},  {30'd0, o_state}, 32'd0);
    check({nm, "/halted"}, {31'd0, o_halted}, 32'd0);
    check({nm, "/stall"},  {31'd0, o_stall}, 32'd0);
    check({nm, "/bcount"}, {16'd0, o_bubble_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_cnt;
    vecs[0]  = mv(1, 3, 4, 1, 0, 0, 0, 32'h1234, 0, mk(1, 1, 0, 0, 32'h1234, 3));
    vecs[1]  = mv(1, 3, 4, 1, 1, 7, 0, 32'h2222, 0, mk(1, 1, 0, 0, 32'h2222, 3));
    vecs[2]  = mv(1, 3, 4, 0, 1, 4, 0, 32'h3333, 0, mk(1, 1, 0, 0, 32'h3333, 3));
    vecs[3]  = mv(1, 2, 5, 1, 1, 5, 0, 32'h5555, 1, mk(0, 0, 0, 1, 32'h5555, 2));
    vecs[4]  = mv(1, 2, 5, 1, 0, 5, 0, 32'h6666, 1, mk(0, 0, 0, 1, 32'h6666, 2));
    vecs[5]  = mv(1, 2, 5, 1, 0, 5, 0, 32'h7777, 1, mk(0, 0, 0, 0, 32'h7777, 2));
    vecs[6]  = mv(1, 2, 5, 1, 0, 5, 0, 32'h8888, 0, mk(1, 1, 0, 0, 32'h8888, 2));
    vecs[7]  = mv(1, 0, 0, 1, 1, 0, 0, 32'h0F0F, 0, mk(1, 1, 0, 0, 32'h0F0F, 0));
    vecs[8]  = mv(1, 9, 1, 1, 1, 9, 1, 32'h9999, 1, mk(0, 0, 0, 0, 32'h9999, 9));
    vecs[9]  = mv(1, 9, 1, 1, 0, 9, 0, 32'hA0A0, 0, mk(1, 1, 0, 0, 32'hA0A0, 9));
    vecs[10] = mv(0, 3, 1, 1, 1, 3, 0, 32'hB0B0, 0, mk(0, 1, 0, 0, 32'hB0B0, 3));

    rst_n = 1'b0; en = 1'b1; vid = 1'b0; uses_rt = 1'b0; mr = 1'b1; halt = 1'b0;
    exmr = 1'b0; flush = 1'b0; rs = 5'd0; rt = 5'd0; exdst = 5'd0; a = 32'd0;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      vid = vecs[i].vid; rs = vecs[i].rs; rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
      exmr = vecs[i].exmr; exdst = vecs[i].exdst; flush = vecs[i].flush;
      halt = vecs[i].halt; a = vecs[i].a;
      step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].e);
      if (i == 6) begin
`ifdef PERF_COUNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        check("bcount_after_hazard", {16'd0, o_bubble_count}, {16'd0, exp_cnt});
      end
    end

    // Freeze while stalled: state and registered outputs hold.
    vid = 1'b1; rs = 5'd6; rt = 5'd0; uses_rt = 1'b0; exmr = 1'b1; exdst = 5'd6; a = 32'hF1;
    step("frz_haz", 1'b1, mk(0, 0, 0, 1, 32'hF1, 6));
    en = 1'b0; exmr = 1'b0; a = 32'hF2;
    for (int k = 0; k < 3; k++) step($sformatf("frz_hold%0d", k), 1'b1, mk(0, 0, 0, 1, 32'hF1, 6));
    en = 1'b1; a = 32'hF3;
    step("frz_resume", 1'b1, mk(0, 0, 0, 1, 32'hF3, 6));
    a = 32'hF4;
    step("frz_done", 1'b1, mk(0, 0, 0, 0, 32'hF4, 6));
`ifdef PERF_COUNT_EN
    exp_cnt = 16'd6;
`else
    exp_cnt = 16'd0;
`endif
    check("bcount_after_freeze", {16'd0, o_bubble_count}, {16'd0, exp_cnt});

    // Halt drain, with a flush during DRAIN and in HALTED that must be ignored.
    rs = 5'd1; halt = 1'b1; a = 32'hAAAA;
    step("halt", 1'b0, mk(1, 1, 1, 2, 32'hAAAA, 1));
    halt = 1'b0; flush = 1'b1; a = 32'hBBBB;
    step("drain1", 1'b1, mk(0, 0, 0, 2, 32'hBBBB, 1));
    flush = 1'b0; a = 32'hCCCC;
    step("drain2", 1'b1, mk(0, 0, 0, 2, 32'hCCCC, 1));
    a = 32'hDDDD;
    step("drain3", 1'b1, mk(0, 0, 0, 3, 32'hDDDD, 1));
    flush = 1'b1; a = 32'hEEEE;
    step("halted_flush", 1'b1, mk(0, 0, 0, 3, 32'hEEEE, 1));
    flush = 1'b0;

    // Leave HALTED, enter DRAIN again, then reset asynchronously between edges.
    rst_n = 1'b0;
    #1;
    check("rst_from_halted/state", {30'd0, o_state}, 32'd0);
    rst_n = 1'b1;
    halt = 1'b1; a = 32'hABCD;
    step("halt2", 1'b0, mk(1, 1, 1, 2, 32'hABCD, 1));
    halt = 1'b0; a = 32'h1357;
    step("drain_b", 1'b1, mk(0, 0, 0, 2, 32'h1357, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid_drain");
    rst_n = 1'b1;
    a = 32'h2468;
    step("post_reset", 1'b0, mk(1, 1, 0, 0, 32'h2468, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Parametrised successor to the MIPS instruction-decode output stage. Registers the decoded ID bundle into the ID/EX pipeline register and adds in-stage load-use hazard detection with configurable bubble count, branch flush, and a halt-drain state machine. Sits between the decoder/register_file/control outputs and the EX stage, and drives the stall signal back to PC/IF.

Parameters:
CANT_REGISTROS, 32, register-file depth; RB = clogb2(CANT_REGISTROS-1) address bits
CANT_BITS_REGISTROS, 32, data width
CANT_BITS_ADDR, 11, PC width
CANT_BITS_CTRL, 12, packed control bundle width (RegDst, RegWrite, ALUSrc, ALUOp, MemWrite, MemtoReg, ALUCtrl)
LOAD_LATENCY, 1, bubbles inserted per load-use hazard, legal range 1..7
HALT_DRAIN, 3, cycles to drain after halt before HALTED, legal range 1..7

Ports:
i_clock  in  1  clock, rising edge
i_soft_reset  in  1  asynchronous reset, active low
i_enable_pipeline  in  1  step enable; low freezes all state
i_valid_id  in  1  ID holds a real instruction
i_reg_rs, i_reg_rt, i_reg_rd  in  RB each  decoded register addresses
i_uses_rt  in  1  instruction reads rt as a source
i_data_A, i_data_B, i_imm_ext  in  CANT_BITS_REGISTROS each  operands and sign-extended immediate
i_ctrl  in  CANT_BITS_CTRL  control bundle
i_mem_read  in  1  MemRead of the ID instruction
i_halt  in  1  decoder halt detect
i_pc  in  CANT_BITS_ADDR  PC+1 from IF
i_ex_mem_read  in  1  instruction currently in EX is a load
i_ex_reg_dst  in  RB  destination register of the EX instruction
i_flush  in  1  branch taken; kill the ID instruction
o_stall  out  1  combinational; hold PC and IF/ID
o_valid, o_mem_read, o_halt_detected  out  1 each  registered
o_data_A, o_data_B, o_imm_ext  out  CANT_BITS_REGISTROS each  registered
o_reg_rs, o_reg_rt, o_reg_rd  out  RB each  registered
o_ctrl  out  CANT_BITS_CTRL  registered
o_pc  out  CANT_BITS_ADDR  registered
o_state  out  2  RUN=0, STALL=1, DRAIN=2, HALTED=3
o_halted  out  1  state==HALTED
o_bubble_count  out  16  hazard bubbles inserted

Behaviour:
- Reset is asynchronous. All registered outputs go to 0, state goes to RUN, and the internal 3-bit counter cnt goes to 0.
- hazard = (state==RUN) & i_valid_id & i_ex_mem_read & (i_ex_reg_dst!=0) & (i_ex_reg_dst==i_reg_rs | (i_uses_rt & i_ex_reg_dst==i_reg_rt)).
- o_stall = hazard | (state!=RUN).
- Bubble definition: o_valid, o_ctrl, o_mem_read and o_halt_detected are 0. Data and address fields still capture their inputs.
- Pipeline latency is one cycle. When i_enable_pipeline=0, every register, the state and cnt hold, and o_stall is still driven.
- Edge priority (enabled edges only): reset, then HALTED, then DRAIN, then flush, then hazard, then halt, then normal.
- RUN:
  - i_flush: load a bubble, stay in RUN.
  - hazard: load a bubble. If LOAD_LATENCY>1, go to STALL with cnt=LOAD_LATENCY-1; otherwise stay in RUN and re-evaluate next cycle.
  - i_halt & i_valid_id: register the instruction with o_halt_detected=1 (one-cycle pulse), go to DRAIN with cnt=HALT_DRAIN.
  - Otherwise: register the inputs with o_valid=i_valid_id.
- STALL: load a bubble and decrement cnt. When cnt==1 at the edge, go to RUN. i_flush returns to RUN immediately with cnt=0.
- DRAIN: load a bubble and decrement cnt. When cnt==1 at the edge, go to HALTED. i_flush is ignored.
- HALTED: load a bubble every cycle. The state is absorbing until reset.
- Register 0 never causes a hazard.
- Reset asserted mid-STALL or mid-DRAIN returns the block to RUN with no pending bubbles.

Optional Feature:
PERF_COUNT_EN
- Defined: o_bubble_count increments once per hazard-triggered bubble (the RUN hazard edge and each STALL edge) on enabled edges. It saturates at 0xFFFF and clears on reset. Flush and drain bubbles are not counted.
- Undefined: no counter logic is built and o_bubble_count is tied to 0.

Test Plan:
- Normal flow: LOAD_LATENCY=1, i_valid_id=1, rs=3, i_data_A=0x1234, no hazard → next cycle o_valid=1, o_data_A=0x1234, o_reg_rs=3, o_stall=0.
- Load-use hazard: LOAD_LATENCY=3, i_ex_mem_read=1, i_ex_reg_dst=5, i_reg_rt=5, i_uses_rt=1.
  - Expect o_stall=1 for 3 cycles and 3 bubbles with o_valid=0, o_state 0→1→1→0.
  - o_bubble_count=3 with PERF_COUNT_EN defined.
- Register-zero guard: i_ex_reg_dst=0=i_reg_rs with i_ex_mem_read=1 → o_stall=0, instruction passes with o_valid=1.
- Flush beats hazard: hazard and i_flush asserted together with LOAD_LATENCY=2 → one bubble, o_state stays 0, next cycle o_stall=0.
- Halt drain: HALT_DRAIN=3, i_halt=1 → o_halt_detected=1 for one cycle, o_state=2 for 3 cycles, then 3 with o_halted=1. A later i_flush is ignored.
- Freeze and reset: drop i_enable_pipeline in STALL → state and outputs hold. Assert i_soft_reset low mid-DRAIN without a clock edge → all outputs 0 and o_state=0 immediately.
